// File: rtl/side_info_packer_2ch_if.sv
// Load bus and output byte stream of the stereo Layer III side-info packer.
// Per-block fields are indexed [gr][ch]; scfsi is indexed [ch][band].
interface side_info_packer_2ch_if;
  logic                        in_valid;
  logic                        in_ready;
  logic [8:0]                  main_data_begin;
  logic [2:0]                  private_bits;
  logic [1:0][3:0]             scfsi;
  logic [1:0][1:0][11:0]       part2_3_length;
  logic [1:0][1:0][8:0]        big_values;
  logic [1:0][1:0][7:0]        global_gain;
  logic [1:0][1:0][3:0]        scalefac_compress;
  logic [1:0][1:0]             window_switching_flag;
  logic [1:0][1:0][1:0]        block_type;
  logic [1:0][1:0]             mixed_block_flag;
  logic [1:0][1:0][2:0][4:0]   table_select;
  logic [1:0][1:0][2:0][2:0]   subblock_gain;
  logic [1:0][1:0][3:0]        region0_count;
  logic [1:0][1:0][2:0]        region1_count;
  logic [1:0][1:0]             preflag;
  logic [1:0][1:0]             scalefac_scale;
  logic [1:0][1:0]             count1table_select;
  logic                        axiov;
  logic [7:0]                  axiod;
  logic                        axiol;
  logic                        axior;

  modport slave (
    input  in_valid, main_data_begin, private_bits, scfsi, part2_3_length,
           big_values, global_gain, scalefac_compress, window_switching_flag,
           block_type, mixed_block_flag, table_select, subblock_gain,
           region0_count, region1_count, preflag, scalefac_scale,
           count1table_select, axior,
    output in_ready, axiov, axiod, axiol
  );

  modport master (
    output in_valid, main_data_begin, private_bits, scfsi, part2_3_length,
           big_values, global_gain, scalefac_compress, window_switching_flag,
           block_type, mixed_block_flag, table_select, subblock_gain,
           region0_count, region1_count, preflag, scalefac_scale,
           count1table_select, axior,
    input  in_ready, axiov, axiod, axiol
  );
endinterface

// File: rtl/side_info_packer_2ch.sv
// Packs one stereo Layer III side-info field set into 32 bytes and streams
// them MSB-first with valid/ready backpressure and a last-byte flag.
module side_info_packer_2ch (
  input logic                    clk,
  input logic                    rst,
  side_info_packer_2ch_if.slave  bus
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [255:0]  r_shift;
  logic [4:0]    r_count;
  logic [19:0]   w_header;
  logic [58:0]   w_blk [2][2];
  logic [255:0]  w_packed;
  logic          w_load;
  logic          w_xfer;
  logic          w_last;

  // scfsi goes out band 0 first, so the packed [3:0] vector is walked upward
  assign w_header = {bus.main_data_begin, bus.private_bits,
                     bus.scfsi[0][0], bus.scfsi[0][1], bus.scfsi[0][2], bus.scfsi[0][3],
                     bus.scfsi[1][0], bus.scfsi[1][1], bus.scfsi[1][2], bus.scfsi[1][3]};

  for (genvar g = 0; g < 2; g++) begin : g_gr
    for (genvar c = 0; c < 2; c++) begin : g_ch
      logic [21:0] w_branch;

      // Both window-switching branches are 22 bits, keeping every block at 59
      assign w_branch = bus.window_switching_flag[g][c]
        ? {bus.block_type[g][c], bus.mixed_block_flag[g][c],
           bus.table_select[g][c][0], bus.table_select[g][c][1],
           bus.subblock_gain[g][c][0], bus.subblock_gain[g][c][1],
           bus.subblock_gain[g][c][2]}
        : {bus.table_select[g][c][0], bus.table_select[g][c][1],
           bus.table_select[g][c][2], bus.region0_count[g][c],
           bus.region1_count[g][c]};

      assign w_blk[g][c] = {bus.part2_3_length[g][c], bus.big_values[g][c],
                            bus.global_gain[g][c], bus.scalefac_compress[g][c],
                            bus.window_switching_flag[g][c], w_branch,
                            bus.preflag[g][c], bus.scalefac_scale[g][c],
                            bus.count1table_select[g][c]};
    end
  end

  assign w_packed = {w_header, w_blk[0][0], w_blk[0][1], w_blk[1][0], w_blk[1][1]};

  assign w_load = bus.in_valid && (r_state == IDLE);
  assign w_xfer = bus.axior && (r_state == SEND);
  assign w_last = (r_count == 5'd31);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid) w_next = SEND;
      SEND:    if (bus.axior && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // The counter wraps 31 -> 0 on the final transfer, ready for the next frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (w_load) begin
      r_shift <= w_packed;
      r_count <= '0;
    end else if (w_xfer) begin
      r_shift <= {r_shift[247:0], 8'h00};
      r_count <= r_count + 5'd1;
    end
  end

  assign bus.in_ready = (r_state == IDLE);
  assign bus.axiov    = (r_state == SEND);
  assign bus.axiod    = r_shift[255:248];
  assign bus.axiol    = (r_state == SEND) && w_last;

endmodule

// File: tb/tb_side_info_packer_2ch.sv
// Self-checking bench for side_info_packer_2ch: directed layout frames, random
// field sets with backpressure, input scrambling during SEND and async reset abort.
module tb_side_info_packer_2ch;

  logic clk = 1'b0;
  logic rst;

  side_info_packer_2ch_if bus ();

  side_info_packer_2ch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]                mdb;
    logic [2:0]                pb;
    logic [1:0][3:0]           scfsi;
    logic [1:0][1:0][11:0]     p23;
    logic [1:0][1:0][8:0]      bv;
    logic [1:0][1:0][7:0]      gg;
    logic [1:0][1:0][3:0]      sfc;
    logic [1:0][1:0]           wsf;
    logic [1:0][1:0][1:0]      bt;
    logic [1:0][1:0]           mbf;
    logic [1:0][1:0][2:0][4:0] ts;
    logic [1:0][1:0][2:0][2:0] sbg;
    logic [1:0][1:0][3:0]      r0;
    logic [1:0][1:0][2:0]      r1;
    logic [1:0][1:0]           pf;
    logic [1:0][1:0]           sfs;
    logic [1:0][1:0]           c1;
  } fs_t;

  int         compared   = 0;
  int         mismatched = 0;
  logic [7:0] rx    [32];
  logic [7:0] rxRef [32];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic fs_t zeroFields();
    fs_t f;
    f.mdb = '0; f.pb = '0; f.scfsi = '0; f.p23 = '0; f.bv = '0; f.gg = '0;
    f.sfc = '0; f.wsf = '0; f.bt = '0; f.mbf = '0; f.ts = '0; f.sbg = '0;
    f.r0 = '0; f.r1 = '0; f.pf = '0; f.sfs = '0; f.c1 = '0;
    return f;
  endfunction

  task automatic randomFields(output fs_t f);
    f.mdb   = 9'($urandom);
    f.pb    = 3'($urandom);
    f.scfsi = 8'($urandom);
    f.p23   = 48'({$urandom(), $urandom()});
    f.bv    = 36'({$urandom(), $urandom()});
    f.gg    = 32'($urandom);
    f.sfc   = 16'($urandom);
    f.wsf   = 4'($urandom);
    f.bt    = 8'($urandom);
    f.mbf   = 4'($urandom);
    f.ts    = 60'({$urandom(), $urandom()});
    f.sbg   = 36'({$urandom(), $urandom()});
    f.r0    = 16'($urandom);
    f.r1    = 12'($urandom);
    f.pf    = 4'($urandom);
    f.sfs   = 4'($urandom);
    f.c1    = 4'($urandom);
  endtask

  task automatic driveFields(input fs_t f);
    bus.main_data_begin       = f.mdb;
    bus.private_bits          = f.pb;
    bus.scfsi                 = f.scfsi;
    bus.part2_3_length        = f.p23;
    bus.big_values            = f.bv;
    bus.global_gain           = f.gg;
    bus.scalefac_compress     = f.sfc;
    bus.window_switching_flag = f.wsf;
    bus.block_type            = f.bt;
    bus.mixed_block_flag      = f.mbf;
    bus.table_select          = f.ts;
    bus.subblock_gain         = f.sbg;
    bus.region0_count         = f.r0;
    bus.region1_count         = f.r1;
    bus.preflag               = f.pf;
    bus.scalefac_scale        = f.sfs;
    bus.count1table_select    = f.c1;
  endtask

  // Reference model: append each field's bits, MSB first, to a growing bitstream
  function automatic void put(inout logic [255:0] r, inout int pos, input logic [31:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      r[pos] = v[k];
      pos--;
    end
  endfunction

  function automatic logic [255:0] packModel(input fs_t f);
    logic [255:0] r = '0;
    int pos = 255;
    put(r, pos, 32'(f.mdb), 9);
    put(r, pos, 32'(f.pb), 3);
    for (int ch = 0; ch < 2; ch++)
      for (int band = 0; band < 4; band++)
        put(r, pos, 32'(f.scfsi[ch][band]), 1);
    for (int gr = 0; gr < 2; gr++) begin
      for (int ch = 0; ch < 2; ch++) begin
        put(r, pos, 32'(f.p23[gr][ch]), 12);
        put(r, pos, 32'(f.bv[gr][ch]), 9);
        put(r, pos, 32'(f.gg[gr][ch]), 8);
        put(r, pos, 32'(f.sfc[gr][ch]), 4);
        put(r, pos, 32'(f.wsf[gr][ch]), 1);
        if (f.wsf[gr][ch]) begin
          put(r, pos, 32'(f.bt[gr][ch]), 2);
          put(r, pos, 32'(f.mbf[gr][ch]), 1);
          put(r, pos, 32'(f.ts[gr][ch][0]), 5);
          put(r, pos, 32'(f.ts[gr][ch][1]), 5);
          for (int w = 0; w < 3; w++) put(r, pos, 32'(f.sbg[gr][ch][w]), 3);
        end else begin
          for (int t = 0; t < 3; t++) put(r, pos, 32'(f.ts[gr][ch][t]), 5);
          put(r, pos, 32'(f.r0[gr][ch]), 4);
          put(r, pos, 32'(f.r1[gr][ch]), 3);
        end
        put(r, pos, 32'(f.pf[gr][ch]), 1);
        put(r, pos, 32'(f.sfs[gr][ch]), 1);
        put(r, pos, 32'(f.c1[gr][ch]), 1);
      end
    end
    return r;
  endfunction

  // Present a field set for one load edge; returns #1 after that edge
  task automatic applyStimulus(input fs_t f);
    driveFields(f);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic receiveFrame(input string tag, input logic [255:0] exp, input bit randReady, input bit scramble);
    int   idx = 0;
    int   cycles = 0;
    fs_t  junk;
    while (idx < 32 && cycles < 2000) begin
      bus.axior = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      if (scramble) begin
        randomFields(junk);
        driveFields(junk);
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      checkOutput($sformatf("%s_valid_b%0d", tag, idx), 32'(bus.axiov), 32'd1);
      checkOutput($sformatf("%s_data_b%0d", tag, idx), 32'(bus.axiod), 32'(exp[255 - 8*idx -: 8]));
      checkOutput($sformatf("%s_last_b%0d", tag, idx), 32'(bus.axiol), 32'(idx == 31));
      checkOutput($sformatf("%s_inready_b%0d", tag, idx), 32'(bus.in_ready), 32'd0);
      rx[idx] = bus.axiod;
      @(posedge clk);
      #1;
      if (bus.axior) idx++;
      cycles++;
    end
    bus.in_valid = 1'b0;
    checkOutput({tag, "_bytes"}, 32'(idx), 32'd32);
    checkOutput({tag, "_bubble_valid"}, 32'(bus.axiov), 32'd0);
    checkOutput({tag, "_bubble_last"}, 32'(bus.axiol), 32'd0);
    checkOutput({tag, "_bubble_inready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    fs_t f;
    logic [255:0] e;

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.axior    = 1'b0;
    driveFields(zeroFields());
    #12;
    checkOutput("reset_axiov", 32'(bus.axiov), 32'd0);
    checkOutput("reset_axiol", 32'(bus.axiol), 32'd0);
    checkOutput("reset_axiod", 32'(bus.axiod), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_inready", 32'(bus.in_ready), 32'd1);

    // All-zero frame
    f = zeroFields();
    applyStimulus(f);
    receiveFrame("t1_zero", packModel(f), 1'b0, 1'b0);
    for (int b = 0; b < 32; b++) checkOutput($sformatf("t1_const_b%0d", b), 32'(rx[b]), 32'd0);

    // main_data_begin all ones
    f = zeroFields();
    f.mdb = 9'h1FF;
    applyStimulus(f);
    receiveFrame("t2_mdb", packModel(f), 1'b0, 1'b0);
    checkOutput("t2_const_b0", 32'(rx[0]), 32'hFF);
    checkOutput("t2_const_b1", 32'(rx[1]), 32'h80);
    checkOutput("t2_const_b2", 32'(rx[2]), 32'h00);

    // part2_3_length of the first block, then its window-switching flag
    f = zeroFields();
    f.p23[0][0] = 12'hFFF;
    applyStimulus(f);
    receiveFrame("t3_p23", packModel(f), 1'b0, 1'b0);
    checkOutput("t3_const_b2", 32'(rx[2]), 32'h0F);
    checkOutput("t3_const_b3", 32'(rx[3]), 32'hFF);
    checkOutput("t3_const_b6", 32'(rx[6]), 32'h00);
    f.wsf[0][0] = 1'b1;
    applyStimulus(f);
    receiveFrame("t3_wsf", packModel(f), 1'b0, 1'b0);
    checkOutput("t3_wsf_const_b6", 32'(rx[6]), 32'h04);

    // Very last bit of the frame
    f = zeroFields();
    f.c1[1][1] = 1'b1;
    applyStimulus(f);
    receiveFrame("t3_c1", packModel(f), 1'b0, 1'b0);
    checkOutput("t3_const_b31", 32'(rx[31]), 32'h01);
    checkOutput("t3_const_b30", 32'(rx[30]), 32'h00);

    // Random field sets, full-rate then with backpressure and scrambled inputs
    for (int n = 0; n < 6; n++) begin
      randomFields(f);
      e = packModel(f);
      applyStimulus(f);
      receiveFrame($sformatf("t4_rand%0d", n), e, 1'b0, 1'b0);
      for (int b = 0; b < 32; b++) rxRef[b] = rx[b];
      applyStimulus(f);
      receiveFrame($sformatf("t5_bp%0d", n), e, 1'b1, 1'b1);
      for (int b = 0; b < 32; b++)
        checkOutput($sformatf("t5_same%0d_b%0d", n, b), 32'(rx[b]), 32'(rxRef[b]));
    end

    // Asynchronous reset while byte 10 is on the bus
    randomFields(f);
    e = packModel(f);
    applyStimulus(f);
    bus.axior = 1'b1;
    for (int b = 0; b < 10; b++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("t6_pre_b10", 32'(bus.axiod), 32'(e[255 - 80 -: 8]));
    bus.axior = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_axiov", 32'(bus.axiov), 32'd0);
    checkOutput("t6_rst_axiol", 32'(bus.axiol), 32'd0);
    checkOutput("t6_rst_axiod", 32'(bus.axiod), 32'd0);
    checkOutput("t6_rst_inready", 32'(bus.in_ready), 32'd1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t6_idle_axiov", 32'(bus.axiov), 32'd0);
    randomFields(f);
    applyStimulus(f);
    receiveFrame("t6_after", packModel(f), 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/side_info_packer_2ch.md
Name: side_info_packer_2ch

Overview:
Serializer for MPEG-1 Layer III stereo side information; the transmit-side counterpart of the 2-channel side-info parser.
- Accepts one complete set of side-info fields in a single load handshake.
- Packs them into the 256-bit (32-byte) bitstream layout.
- Emits the result MSB-first as a byte stream with valid/ready backpressure and a last-byte flag.
- Used by the frame assembler and by the parser round-trip bench.

Parameters:
none (layout is fixed: 2 channels, 2 granules, 32 bytes)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  field set presented
- in_ready  out  1  packer idle, can accept a field set
- main_data_begin  in  9
- private_bits  in  3
- scfsi  in  [1:0][3:0]  [ch][band]
- part2_3_length  in  [1:0][1:0][11:0]  all per-block fields indexed [gr][ch]
- big_values  in  [1:0][1:0][8:0]
- global_gain  in  [1:0][1:0][7:0]
- scalefac_compress  in  [1:0][1:0][3:0]
- window_switching_flag  in  [1:0][1:0]
- block_type  in  [1:0][1:0][1:0]
- mixed_block_flag  in  [1:0][1:0]
- table_select  in  [1:0][1:0][2:0][4:0]
- subblock_gain  in  [1:0][1:0][2:0][2:0]
- region0_count  in  [1:0][1:0][3:0]
- region1_count  in  [1:0][1:0][2:0]  3 bits; the implicit 12/13 values are never transmitted
- preflag  in  [1:0][1:0]
- scalefac_scale  in  [1:0][1:0]
- count1table_select  in  [1:0][1:0]
- axiov  out  1  output byte valid
- axiod  out  8  output byte
- axiol  out  1  high with byte 31 of the frame
- axior  in  1  downstream ready

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset state:
  - state = IDLE; axiov = 0, axiol = 0, axiod = 0x00.
  - byte counter = 0; shift register = 0.
  - in_ready = 1 once rst deasserts.
- in_ready is (state == IDLE), driven only by registered state.
- Bit layout, first bit = bit 255 of the shift register = MSB of byte 0:
  - Header: main_data_begin(9), private_bits(3), scfsi[0][0..3], scfsi[1][0..3] = 20 bits.
  - Then, for gr = 0..1, ch = 0..1 (granule outer), 59 bits each:
    - part2_3_length(12), big_values(9), global_gain(8), scalefac_compress(4), window_switching_flag(1).
    - If wsf = 1: block_type(2), mixed_block_flag(1), table_select[0](5), table_select[1](5), subblock_gain[0..2](3 each).
    - If wsf = 0: table_select[0..2](5 each), region0_count(4), region1_count(3).
    - Both branches carry 22 bits.
    - Then preflag, scalefac_scale, count1table_select (1 each).
  - Fields unused by the selected branch are ignored. For wsf = 0 that is block_type, mixed_block_flag and subblock_gain; for wsf = 1 that is table_select[2] and the region counts.
  - Total is 20 + 4*59 = 256 bits exactly; no padding.
- Load: when in_valid && in_ready at a clock edge:
  - The packed 256-bit word is captured into the shift register.
  - state goes to SEND, counter = 0, axiov = 1, axiod = byte 0.
  - Latency is 1 cycle from the load edge to the first valid byte.
- SEND:
  - A byte transfers on each edge with axiov && axior.
  - On each transfer: the register shifts left by 8, the counter increments, and axiod shows the next byte.
  - axiol = 1 exactly while the counter is 31.
  - If axior = 0, axiov, axiod, axiol and the counter hold.
- Completion: the transfer of byte 31 moves state to IDLE, with axiov = 0, axiol = 0 and in_ready = 1 on the next cycle.
  - There is always one idle bubble cycle between frames.
- Field inputs are sampled only on the load edge; later changes have no effect on the frame in flight.
- in_valid during SEND is ignored; the field set must be held until in_ready.
- rst mid-frame aborts immediately: the outputs take their reset values and the partial frame is discarded.

Test Plan:
1. All fields 0, wsf = 0, axior = 1 → 32 consecutive bytes of 0x00 on the cycles after load; axiol high only on the 32nd; in_ready low for 32 cycles, then 1 bubble.
2. main_data_begin = 0x1FF, all else 0 → byte0 = 0xFF, byte1 = 0x80, bytes 2–31 = 0x00.
3. part2_3_length[0][0] = 0xFFF → byte2 = 0x0F, byte3 = 0xFF; with window_switching_flag[0][0] = 1 added → byte6 = 0x04. count1table_select[1][1] = 1 → byte31 = 0x01.
4. Random field sets with wsf mixed and unused fields randomized → the stream fed to side_info_2ch reproduces every transmitted field. When wsf = 1, the parser's region counts are 8/12 if block_type = 2 and mixed = 0, else 7/13.
5. Backpressure: axior toggles randomly → byte sequence identical to the axior = 1 run; axiod stable while axiov && !axior. Field inputs changed during SEND → no effect on the frame.
6. rst pulsed asynchronously at byte 10 → outputs clear without waiting for clk; the next load emits the new frame starting at byte 0.
